// File: rtl/song_pkg.sv
// Shared definitions for the song ROM readers: default widths, metadata
// word layout and the block fetcher state encoding.
package song_pkg;

  localparam int NOTE_W             = 16;
  localparam int ADDR_W             = 9;
  localparam int SIZE_W             = 3;
  localparam int MAX_SONG_NOTE_ADDR = 447;

  // Block ROM word layout: {start_addr, prev_size, curr_size}
  localparam int META_W    = ADDR_W + 2 * SIZE_W;
  localparam int START_LSB = 2 * SIZE_W;
  localparam int PREV_LSB  = SIZE_W;
  localparam int CURR_LSB  = 0;

  // Block fetcher FSM encoding, kept as plain constants so older readers
  // that store the state in a bare vector can share it.
  localparam int         STATE_W     = 3;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_META_RD  = 3'd1;
  localparam logic [2:0] ST_META_CAP = 3'd2;
  localparam logic [2:0] ST_FETCH    = 3'd3;
  localparam logic [2:0] ST_TAIL     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/song_note_addr_clamp.sv
// Song note address generator: start + offset, saturated at the last valid
// note address so a block running past the end of the song never wraps.
module song_note_addr_clamp #(
  parameter int ADDR_W   = song_pkg::ADDR_W,
  parameter int OFF_W    = 4,
  parameter int MAX_ADDR = song_pkg::MAX_SONG_NOTE_ADDR
) (
  input  logic [ADDR_W-1:0] i_start,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [ADDR_W-1:0] o_addr
);

  // One extra bit so a sum past the top of the address space is still seen
  logic [ADDR_W:0] w_sum;

  // Widened sum, then saturate against the last valid address
  always_comb begin
    w_sum = {1'b0, i_start} + (ADDR_W + 1)'(i_offset);
    if (w_sum > (ADDR_W + 1)'(MAX_ADDR)) begin
      o_addr = ADDR_W'(MAX_ADDR);
    end else begin
      o_addr = w_sum[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/song_block_fetcher.sv
// Song block fetcher: looks up a block's metadata, then reads its notes one
// per cycle through a single song ROM port and presents them as a vector.
module song_block_fetcher
  import song_pkg::*;
#(
  parameter int NOTE_W        = song_pkg::NOTE_W,
  parameter int ADDR_W        = song_pkg::ADDR_W,
  parameter int BLK_IDX_W     = 9,
  parameter int SIZE_W        = song_pkg::SIZE_W,
  parameter int MAX_NOTES     = 4,
  parameter int MAX_NOTE_ADDR = song_pkg::MAX_SONG_NOTE_ADDR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [BLK_IDX_W-1:0]          req_block_idx,
  output logic [BLK_IDX_W-1:0]          meta_addr,
  input  logic [ADDR_W+2*SIZE_W-1:0]    meta_dout,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [NOTE_W-1:0]             rom_dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_NOTES*NOTE_W-1:0]   out_notes,
  output logic [MAX_NOTES-1:0]          out_note_mask,
  output logic [SIZE_W-1:0]             out_block_size,
  output logic [SIZE_W-1:0]             out_prev_size,
  output logic                          out_trunc
);

  // Counter wide enough to hold the note count n itself (0..MAX_NOTES)
  localparam int CNT_W = $clog2(MAX_NOTES + 1);

  logic [2:0]                  r_state;
  logic [BLK_IDX_W-1:0]        r_idx;
  logic [ADDR_W-1:0]           r_start;
  logic [CNT_W-1:0]            r_n;
  logic [CNT_W-1:0]            r_cnt;
  logic [ADDR_W-1:0]           r_rom_addr;
  logic [MAX_NOTES*NOTE_W-1:0] r_notes;
  logic [MAX_NOTES-1:0]        r_mask;
  logic [SIZE_W-1:0]           r_size;
  logic [SIZE_W-1:0]           r_prev;
  logic                        r_trunc;

  logic [ADDR_W-1:0] w_meta_start;
  logic [SIZE_W-1:0] w_meta_prev;
  logic [SIZE_W-1:0] w_meta_curr;
  logic              w_trunc;
  logic [CNT_W-1:0]  w_n;
  logic [ADDR_W-1:0] w_clamp_base;
  logic [CNT_W-1:0]  w_clamp_off;
  logic [ADDR_W-1:0] w_clamp_addr;
  logic              w_capture;
  logic [CNT_W-1:0]  w_lane;

  assign req_ready      = (r_state == ST_IDLE);
  assign out_valid      = (r_state == ST_DONE);
  assign meta_addr      = r_idx;
  assign rom_addr       = r_rom_addr;
  assign out_notes      = r_notes;
  assign out_note_mask  = r_mask;
  assign out_block_size = r_size;
  assign out_prev_size  = r_prev;
  assign out_trunc      = r_trunc;

  // Split the metadata word and derive the number of lanes to fill
  always_comb begin
    w_meta_start = meta_dout[2*SIZE_W +: ADDR_W];
    w_meta_prev  = meta_dout[SIZE_W +: SIZE_W];
    w_meta_curr  = meta_dout[0 +: SIZE_W];
    w_trunc      = (int'(w_meta_curr) > MAX_NOTES);
    if (w_trunc) begin
      w_n = CNT_W'(MAX_NOTES);
    end else begin
      w_n = CNT_W'(w_meta_curr);
    end
  end

  // Next address to issue: note 0 straight from metadata, then start + cnt + 1
  always_comb begin
    if (r_state == ST_META_CAP) begin
      w_clamp_base = w_meta_start;
      w_clamp_off  = '0;
    end else begin
      w_clamp_base = r_start;
      w_clamp_off  = r_cnt + CNT_W'(1);
    end
  end

  song_note_addr_clamp #(
    .ADDR_W   (ADDR_W),
    .OFF_W    (CNT_W),
    .MAX_ADDR (MAX_NOTE_ADDR)
  ) u_addr_clamp (
    .i_start  (w_clamp_base),
    .i_offset (w_clamp_off),
    .o_addr   (w_clamp_addr)
  );

  // ROM data lags the address by one cycle, so the lane written trails cnt
  always_comb begin
    if (r_state == ST_TAIL) begin
      w_capture = 1'b1;
      w_lane    = r_n - CNT_W'(1);
    end else if (r_state == ST_FETCH) begin
      w_capture = (r_cnt != '0);
      w_lane    = r_cnt - CNT_W'(1);
    end else begin
      w_capture = 1'b0;
      w_lane    = '0;
    end
  end

  // Sequencer: request, metadata read/capture, note fetch, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_start    <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_size     <= '0;
      r_prev     <= '0;
      r_trunc    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_idx   <= req_block_idx;
            r_state <= ST_META_RD;
          end
        end
        ST_META_RD: begin
          r_state <= ST_META_CAP;
        end
        ST_META_CAP: begin
          r_start <= w_meta_start;
          r_prev  <= w_meta_prev;
          r_size  <= w_meta_curr;
          r_trunc <= w_trunc;
          r_n     <= w_n;
          r_cnt   <= '0;
          if (w_n == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_rom_addr <= w_clamp_addr;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (r_cnt == r_n - CNT_W'(1)) begin
            r_state <= ST_TAIL;
          end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_rom_addr <= w_clamp_addr;
          end
        end
        ST_TAIL: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Note lanes and mask: cleared per block, filled as ROM data returns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_notes <= '0;
      r_mask  <= '0;
    end else if (r_state == ST_META_CAP) begin
      r_notes <= '0;
      r_mask  <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < MAX_NOTES; i++) begin
        if (w_lane == CNT_W'(i)) begin
          r_notes[i*NOTE_W +: NOTE_W] <= rom_dout;
          r_mask[i]                   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_song_block_fetcher.sv
// Bench for song_block_fetcher: ROM models, directed block cases, random
// block requests with random backpressure, checked against a block model.
module tb_song_block_fetcher;

  localparam int P_MAX_NOTES = 4;
  localparam int NW   = 16;
  localparam int AW   = 9;
  localparam int IW   = 9;
  localparam int SW   = 3;
  localparam int MAXA = 447;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid;
  logic                     req_ready;
  logic [IW-1:0]            req_block_idx;
  logic [IW-1:0]            meta_addr;
  logic [AW+2*SW-1:0]       meta_dout;
  logic [AW-1:0]            rom_addr;
  logic [NW-1:0]            rom_dout;
  logic                     out_valid;
  logic                     out_ready;
  logic [P_MAX_NOTES*NW-1:0] out_notes;
  logic [P_MAX_NOTES-1:0]   out_note_mask;
  logic [SW-1:0]            out_block_size;
  logic [SW-1:0]            out_prev_size;
  logic                     out_trunc;

  int n_checks = 0;
  int n_errors = 0;

  song_block_fetcher #(
    .NOTE_W (NW), .ADDR_W (AW), .BLK_IDX_W (IW), .SIZE_W (SW),
    .MAX_NOTES (P_MAX_NOTES), .MAX_NOTE_ADDR (MAXA)
  ) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_block_idx (req_block_idx),
    .meta_addr (meta_addr), .meta_dout (meta_dout),
    .rom_addr (rom_addr), .rom_dout (rom_dout),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_notes (out_notes), .out_note_mask (out_note_mask),
    .out_block_size (out_block_size), .out_prev_size (out_prev_size),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  // Block ROM contents: directed blocks plus an arithmetic fill elsewhere
  function automatic logic [AW+2*SW-1:0] meta_of(input logic [IW-1:0] idx);
    int st, pv, cu;
    case (idx)
      9'd5:    begin st = 10;  pv = 2; cu = 4; end
      9'd6:    begin st = 446; pv = 1; cu = 4; end
      9'd7:    begin st = 100; pv = 3; cu = 0; end
      9'd8:    begin st = 20;  pv = 1; cu = 6; end
      default: begin
        st = (int'(idx) * 37 + 11) % 512;
        pv = int'(idx) % 8;
        cu = (int'(idx) * 3) % 8;
      end
    endcase
    return {st[AW-1:0], pv[SW-1:0], cu[SW-1:0]};
  endfunction

  function automatic int clamp_ref(input int a);
    return (a > MAXA) ? MAXA : a;
  endfunction

  // Block ROM: one-cycle synchronous read
  always @(posedge clk) meta_dout <= meta_of(meta_addr);

  // Song ROM: one-cycle synchronous read, note = 0x1000 + address
  always @(posedge clk) rom_dout <= 16'h1000 + {7'd0, rom_addr};

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One block request, checked for latency, addresses, result and backpressure
  task automatic do_req(input logic [IW-1:0] idx, input int hold);
    logic [AW+2*SW-1:0]        m;
    logic [P_MAX_NOTES*NW-1:0] en;
    logic [P_MAX_NOTES-1:0]    em;
    int st, pv, cu, n, lat, cyc, t, a, addr_before, over;
    m  = meta_of(idx);
    st = int'(m[AW+2*SW-1:2*SW]);
    pv = int'(m[2*SW-1:SW]);
    cu = int'(m[SW-1:0]);
    n  = (cu > P_MAX_NOTES) ? P_MAX_NOTES : cu;
    en = '0;
    em = '0;
    for (int i = 0; i < n; i++) begin
      a = clamp_ref(st + i);
      en[i*NW +: NW] = NW'(32'h1000 + a);
      em[i] = 1'b1;
    end
    lat = (n == 0) ? 3 : 4 + n;

    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("req_ready_idle", req_ready, 1'b1);
    addr_before   = int'(rom_addr);
    req_valid     = 1'b1;
    req_block_idx = idx;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    req_valid = 1'b0;
    over = 0;
    while (!out_valid && cyc < 40) begin
      if (cyc >= 3 && cyc < 3 + n) check_val("rom_addr_issue", rom_addr, clamp_ref(st + cyc - 3));
      if (n == 0) check_val("rom_addr_quiet", rom_addr, addr_before);
      if (int'(rom_addr) > MAXA) over++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_val("latency", cyc, lat);
    check_val("out_valid", out_valid, 1'b1);
    check_val("notes", out_notes, en);
    check_val("mask", out_note_mask, em);
    check_val("block_size", out_block_size, cu);
    check_val("prev_size", out_prev_size, pv);
    check_val("trunc", out_trunc, (cu > P_MAX_NOTES));
    check_val("req_ready_busy", req_ready, 1'b0);
    check_val("rom_addr_range", over, 0);

    // A competing request during backpressure must be ignored
    if (hold > 0) begin
      req_valid     = 1'b1;
      req_block_idx = idx ^ 9'd1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", out_valid, 1'b1);
      check_val("hold_notes", out_notes, en);
      check_val("hold_mask", out_note_mask, em);
      check_val("hold_req_ready", req_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 1'b0;
    check_val("release_valid", out_valid, 1'b0);
    check_val("release_req_ready", req_ready, 1'b1);
  endtask

  // Reset asserted while notes are being fetched
  task automatic reset_mid_fetch();
    int seen;
    req_valid     = 1'b1;
    req_block_idx = 9'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_req_ready", req_ready, 1'b1);
    check_val("midrst_valid", out_valid, 1'b0);
    check_val("midrst_mask", out_note_mask, '0);
    check_val("midrst_notes", out_notes, '0);
    check_val("midrst_rom_addr", rom_addr, '0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("midrst_no_valid", seen, 0);
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_block_idx = '0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", req_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_meta_addr", meta_addr, '0);
    check_val("rst_rom_addr", rom_addr, '0);
    check_val("rst_notes", out_notes, '0);
    check_val("rst_mask", out_note_mask, '0);
    check_val("rst_size", out_block_size, '0);
    check_val("rst_prev", out_prev_size, '0);
    check_val("rst_trunc", out_trunc, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    reset_mid_fetch();

    do_req(9'd5, 0);
    do_req(9'd6, 0);
    do_req(9'd7, 0);
    do_req(9'd8, 0);
    do_req(9'd5, 10);
    do_req(9'd6, 0);

    for (int r = 0; r < 30; r++) begin
      do_req(IW'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
